// File: rtl/mem_req_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_seq
// Brief    : Arbitrates Hack CPU fetch / data-read / data-write requests and
//            sequences one SPI memory transaction at a time, returning a
//            one-cycle done pulse per request and a CPU stall.
//            Optional macro MEM_TIMEOUT_EN adds a transaction timeout and a
//            sticky err_o flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_seq #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        fetch_req_i,
    input  logic [15:0] pc_i,
    input  logic        rd_req_i,
    input  logic        wr_req_i,
    input  logic [15:0] daddr_i,
    input  logic [15:0] wdata_i,
    input  logic        spi_csb_i,
    output logic        spi_start_o,
    output logic        spi_rwb_o,
    output logic        spi_sel_dest_o,
    output logic [15:0] spi_addr_o,
    output logic [15:0] spi_data_o,
    output logic        fetch_done_o,
    output logic        data_done_o,
    output logic        cpu_stall_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    // With no gap configured the FSM returns straight to IDLE after done.
    localparam state_t c_POST_DONE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_req_any;
    logic               w_csb_rise;
    logic               w_timeout;
    logic               w_done;
    logic [c_GAP_W-1:0] r_gap_cnt;

    assign w_req_any  = fetch_req_i | rd_req_i | wr_req_i;
    assign w_csb_rise = (r_state == S_WAIT_HIGH) && spi_csb_i;
    assign w_done     = w_csb_rise | w_timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;
    logic              w_waiting;

    assign w_waiting = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH);
    // A genuine chip-select return in the same cycle wins over the timeout.
    assign w_timeout = w_waiting && (r_to_cnt == c_TO_LIMIT) && !w_csb_rise;
    assign err_o     = r_err;

    // Timeout counter: zero on entry into WAIT_LOW, saturates at the limit.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt <= '0;
        end else if (w_waiting && (r_to_cnt != c_TO_LIMIT)) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; requests are sampled only in IDLE.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_next = S_ISSUE;
                    w_load = 1'b1;
                end
            end
            S_ISSUE:     w_next = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (w_timeout) begin
                    w_next = c_POST_DONE;
                end else if (!spi_csb_i) begin
                    w_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_done) begin
                    w_next = c_POST_DONE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    // Gap counter runs only while in GAP.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_gap_cnt <= '0;
        end else if (r_state != S_GAP) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        end
    end

    // Transaction descriptor: captured once in IDLE, held until the next load.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            spi_addr_o     <= 16'h0000;
            spi_data_o     <= 16'h0000;
            spi_rwb_o      <= 1'b1;
            spi_sel_dest_o <= 1'b0;
        end else if (w_load) begin
            if (wr_req_i) begin
                spi_addr_o     <= daddr_i;
                spi_data_o     <= wdata_i;
                spi_rwb_o      <= 1'b0;
                spi_sel_dest_o <= 1'b1;
            end else if (rd_req_i) begin
                spi_addr_o     <= daddr_i;
                spi_rwb_o      <= 1'b1;
                spi_sel_dest_o <= 1'b1;
            end else begin
                spi_addr_o     <= pc_i;
                spi_rwb_o      <= 1'b1;
                spi_sel_dest_o <= 1'b0;
            end
        end
    end

    assign spi_start_o  = (r_state == S_ISSUE);
    // The descriptor's destination identifies the owning request.
    assign fetch_done_o = w_done & ~spi_sel_dest_o;
    assign data_done_o  = w_done &  spi_sel_dest_o;
    // Stall releases on the done pulse so the CPU can consume the result.
    assign cpu_stall_o  = resetb & ~w_done & (w_req_any | (r_state != S_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_mem_req_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_seq
// Brief    : Directed self-checking bench for mem_req_seq with a simple SPI
//            chip-select model (low 2 cycles after start, for 40 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_seq;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] daddr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        spi_csb;
    logic        spi_start;
    logic        spi_rwb;
    logic        spi_sel_dest;
    logic [15:0] spi_addr;
    logic [15:0] spi_data;
    logic        fetch_done;
    logic        data_done;
    logic        cpu_stall;
    logic        err;

    logic        stuck = 1'b0;
    logic [5:0]  ph;
    int          cyc = 0;
    int          n_fd = 0;
    int          n_dd = 0;
    int          n_st = 0;
    int          n_vec = 0;
    int          n_err = 0;

    mem_req_seq dut (
        .clk            (clk),
        .resetb         (resetb),
        .fetch_req_i    (fetch_req),
        .pc_i           (pc),
        .rd_req_i       (rd_req),
        .wr_req_i       (wr_req),
        .daddr_i        (daddr),
        .wdata_i        (wdata),
        .spi_csb_i      (spi_csb),
        .spi_start_o    (spi_start),
        .spi_rwb_o      (spi_rwb),
        .spi_sel_dest_o (spi_sel_dest),
        .spi_addr_o     (spi_addr),
        .spi_data_o     (spi_data),
        .fetch_done_o   (fetch_done),
        .data_done_o    (data_done),
        .cpu_stall_o    (cpu_stall),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // SPI model: chip-select low in phases 2..41 after a seen start.
    always @(posedge clk or negedge resetb) begin
        if (!resetb)          ph <= 6'd0;
        else if (ph == 6'd0)  ph <= (spi_start && !stuck) ? 6'd1 : 6'd0;
        else if (ph == 6'd41) ph <= 6'd0;
        else                  ph <= ph + 6'd1;
    end
    assign spi_csb = !((ph >= 6'd2) && (ph <= 6'd41));

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fetch_done) n_fd = n_fd + 1;
        if (data_done)  n_dd = n_dd + 1;
        if (spi_start)  n_st = n_st + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, output int t);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (spi_start) break;
        end
        chk({tag, "_start_timeout"}, (k == 200), 0);
        t = cyc;
    endtask

    task automatic wait_done(input string tag, input int lim, output int t, output logic st_ok);
        int k;
        st_ok = 1'b1;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (fetch_done || data_done) break;
            if (!cpu_stall) st_ok = 1'b0;
        end
        chk({tag, "_done_timeout"}, (k == lim), 0);
        t = cyc;
    endtask

    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] d,
                           input logic rwb, input logic sel, output int ts, output int td);
        logic st_ok;
        wait_start(tag, ts);
        chk({tag, "_addr"}, spi_addr, a);
        chk({tag, "_rwb"}, spi_rwb, rwb);
        chk({tag, "_sel"}, spi_sel_dest, sel);
        chk({tag, "_stall_at_start"}, cpu_stall, 1);
        if (!rwb) chk({tag, "_wdata"}, spi_data, d);
        wait_done(tag, 100, td, st_ok);
        chk({tag, "_stall_until_done"}, st_ok, 1);
        chk({tag, "_fetch_done"}, fetch_done, !sel);
        chk({tag, "_data_done"}, data_done, sel);
        if (!sel)      fetch_req = 1'b0;
        else if (!rwb) wr_req = 1'b0;
        else           rd_req = 1'b0;
    endtask

    initial begin
        int ts, td, ts2, td2, nd;
        logic st_ok;

        // Reset values; stall forced low even with a request pending.
        fetch_req = 1'b1;
        pc = 16'h0010;
        repeat (3) @(negedge clk);
        chk("rst_start", spi_start, 0);
        chk("rst_rwb", spi_rwb, 1);
        chk("rst_sel", spi_sel_dest, 0);
        chk("rst_addr", spi_addr, 16'h0000);
        chk("rst_data", spi_data, 16'h0000);
        chk("rst_done", {fetch_done, data_done}, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_err", err, 0);
        resetb = 1'b1;

        // 1: single fetch, done 42 cycles after start.
        run_txn("t1", 16'h0010, 16'h0000, 1'b1, 1'b0, ts, td);
        chk("t1_latency", td - ts, 42);
        repeat (8) @(negedge clk);
        chk("t1_one_start", n_st, 1);
        chk("t1_idle_stall", cpu_stall, 0);

        // 2: single write.
        daddr = 16'h1234; wdata = 16'hBEEF; wr_req = 1'b1;
        nd = n_fd;
        run_txn("t2", 16'h1234, 16'hBEEF, 1'b0, 1'b1, ts, td);
        repeat (8) @(negedge clk);
        chk("t2_no_fetch_done", n_fd, nd);

        // 3: all three at once: write, read, fetch with enforced gaps.
        nd = n_fd + n_dd;
        pc = 16'h0100; daddr = 16'h2000; wdata = 16'h5555;
        fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        run_txn("t3w", 16'h2000, 16'h5555, 1'b0, 1'b1, ts, td);
        run_txn("t3r", 16'h2000, 16'h0000, 1'b1, 1'b1, ts2, td2);
        chk("t3_gap_wr", (ts2 - td) >= 3, 1);
        run_txn("t3f", 16'h0100, 16'h0000, 1'b1, 1'b0, ts, td);
        chk("t3_gap_rd", (ts - td2) >= 3, 1);
        repeat (8) @(negedge clk);
        chk("t3_three_dones", n_fd + n_dd - nd, 3);

        // 4: asynchronous reset while chip-select is low.
        pc = 16'h0200; fetch_req = 1'b1;
        wait_start("t4", ts);
        repeat (10) @(negedge clk);
        chk("t4_csb_low", spi_csb, 0);
        nd = n_fd + n_dd;
        #2 resetb = 1'b0;
        #1;
        chk("t4_async_addr", spi_addr, 16'h0000);
        chk("t4_async_rwb", spi_rwb, 1);
        chk("t4_async_stall", cpu_stall, 0);
        chk("t4_async_done", {fetch_done, data_done}, 0);
        repeat (3) @(negedge clk);
        chk("t4_no_done", n_fd + n_dd, nd);
        resetb = 1'b1;
        run_txn("t4f", 16'h0200, 16'h0000, 1'b1, 1'b0, ts, td);
        repeat (8) @(negedge clk);

        // 5: chip-select never falls.
        stuck = 1'b1; daddr = 16'h0300; rd_req = 1'b1;
        nd = n_dd;
        wait_start("t5", ts);
`ifdef MEM_TIMEOUT_EN
        wait_done("t5", 200, td, st_ok);
        chk("t5_to_latency", td - ts, 65);
        chk("t5_to_data_done", data_done, 1);
        rd_req = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err, 1);
        repeat (10) @(negedge clk);
        chk("t5_err_sticky", err, 1);
`else
        repeat (120) @(negedge clk);
        chk("t5_no_done", n_dd, nd);
        chk("t5_err_zero", err, 0);
        chk("t5_still_stalled", cpu_stall, 1);
        rd_req = 1'b0;
`endif
        resetb = 1'b0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_err_cleared", err, 0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // 6: read request dropped mid-transfer still completes, no re-issue.
        daddr = 16'h0400; rd_req = 1'b1;
        nd = n_st;
        wait_start("t6", ts);
        chk("t6_addr", spi_addr, 16'h0400);
        repeat (10) @(negedge clk);
        rd_req = 1'b0;
        wait_done("t6", 100, td, st_ok);
        chk("t6_data_done", data_done, 1);
        chk("t6_latency", td - ts, 42);
        repeat (12) @(negedge clk);
        chk("t6_single_start", n_st - nd, 1);
        chk("t6_idle_stall", cpu_stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
